karatsuba_seq_ctrl: RTL and testbench

- Sequential controller that computes an M x M carry-less (GF(2) polynomial) product.
- Time-shares a single internal H x H carry-less multiplier (H = M/2) across the three Karatsuba sub-products: low, high and middle.
- Sits between an operand source and a result consumer, with valid/ready handshakes on both sides.
- Trades throughput for area compared with the fully parallel combinational Karatsuba multipliers.

---
 rtl/karatsuba_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_karatsuba_seq_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_seq_ctrl.sv
// rtl/karatsuba_seq_ctrl.sv - sequential M x M carry-less Karatsuba multiplier controller
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair A/B offered
//   in_ready   controller idle and able to take operands
//   A, B       M-bit operand polynomials (bit i = coefficient of x^i)
//   out_valid  product C presented
//   out_ready  consumer takes C
//   C          (2M-1)-bit carry-less product A*B over GF(2)
//   busy       an operation is in flight or waiting to be consumed

module karatsuba_seq_ctrl #(
  parameter int M = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   A,
  input  logic [M-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*M-2:0] C,
  output logic           busy
);

  localparam int H  = M / 2;
  localparam int N  = 2 * M - 1;
  localparam int ZW = 2 * H - 1;

  typedef enum logic [2:0] {
    IDLE,
    MUL_LO,
    MUL_HI,
    MUL_MID,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [M-1:0]  ar;
  logic [M-1:0]  br;
  logic [ZW-1:0] p0;
  logic [ZW-1:0] p2;

  logic [H-1:0]  x;
  logic [H-1:0]  y;
  logic [ZW-1:0] z;
  logic [ZW-1:0] mid;
  logic [N-1:0]  t_hi;
  logic [N-1:0]  t_mid;
  logic [N-1:0]  t_lo;
  logic [N-1:0]  c_next;

  // Shift-and-xor convolution of two H-bit polynomials.
  function automatic logic [ZW-1:0] clmul_h(input logic [H-1:0] a, input logic [H-1:0] b);
    logic [ZW-1:0] acc;
    acc = '0;
    for (int i = 0; i < H; i++) begin
      if (b[i]) begin
        acc = acc ^ ({{(ZW-H){1'b0}}, a} << i);
      end
    end
    return acc;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, handshake outputs and the operand mux for the shared multiplier.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    x          = '0;
    y          = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = MUL_LO;
        end
      end
      MUL_LO: begin
        x          = ar[H-1:0];
        y          = br[H-1:0];
        state_next = MUL_HI;
      end
      MUL_HI: begin
        x          = ar[M-1:H];
        y          = br[M-1:H];
        state_next = MUL_MID;
      end
      MUL_MID: begin
        x          = ar[H-1:0] ^ ar[M-1:H];
        y          = br[H-1:0] ^ br[M-1:H];
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign z = clmul_h(x, y);

  // In MUL_MID z is P1; the middle term is P1 ^ P0 ^ P2.
  assign mid    = z ^ p0 ^ p2;
  assign t_hi   = {p2, {M{1'b0}}};
  assign t_mid  = {{H{1'b0}}, mid, {H{1'b0}}};
  assign t_lo   = {{M{1'b0}}, p0};
  assign c_next = t_hi ^ t_mid ^ t_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      ar <= '0;
      br <= '0;
      p0 <= '0;
      p2 <= '0;
      C  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ar <= A;
            br <= B;
          end
        end
        MUL_LO:  p0 <= z;
        MUL_HI:  p2 <= z;
        MUL_MID: C  <= c_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// tb/tb_karatsuba_seq_ctrl.sv - self-checking bench for karatsuba_seq_ctrl
`timescale 1ns/1ps

module tb_karatsuba_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] C;
  logic        busy;

  int chk_cnt;
  int pass_cnt;

  karatsuba_seq_ctrl #(.M(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit-by-bit convolution, independent of any Karatsuba split.
  function automatic logic [14:0] ref_clmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        r[i+j] = r[i+j] ^ (a[i] & b[j]);
      end
    end
    return r;
  endfunction

  // One operation with out_ready high, checking latency and return to IDLE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [14:0] exp, input string tag);
    out_ready = 1'b1;
    check({tag, "_in_ready_pre"}, in_ready, 1);
    in_valid = 1'b1;
    A = a;
    B = b;
    tick();
    in_valid = 1'b0;
    A = ~a;
    B = 8'h5A;
    check({tag, "_busy_lo"}, {busy, in_ready}, 2'b10);
    tick();
    tick();
    check({tag, "_valid_early"}, out_valid, 0);
    tick();
    check({tag, "_valid_k3"}, out_valid, 1);
    check({tag, "_C"}, C, exp);
    tick();
    check({tag, "_after"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    logic [14:0] exp_q[$];
    logic [14:0] exp_v;
    logic [7:0]  pa;
    logic [7:0]  pb;
    int          sent;
    int          got;
    int          cyc;
    logic        acc;

    chk_cnt   = 0;
    pass_cnt  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    tick();
    tick();
    check("rst_state", {out_valid, busy, in_ready}, 3'b001);
    check("rst_C", C, 0);
    rst = 1'b0;
    tick();

    // Directed products
    run_op(8'h03, 8'h03, 15'h0005, "p03");
    run_op(8'h12, 8'h34, 15'h0328, "p12");
    run_op(8'hFF, 8'hFF, 15'h5555, "pFF");
    run_op(8'h80, 8'h80, 15'h4000, "p80");
    run_op(8'h00, 8'hA7, 15'h0000, "p00");

    // Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    A = 8'h12;
    B = 8'h34;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      check("bp_hold", {out_valid, in_ready, busy, 1'b0, C}, {4'b1010, 15'h0328});
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release", {out_valid, in_ready}, 2'b01);

    // in_valid during MUL_LO..DONE is ignored
    in_valid = 1'b1;
    A = 8'h03;
    B = 8'h03;
    tick();
    A = 8'hFF;
    B = 8'hFF;
    tick();
    tick();
    tick();
    check("busy_in_C", C, 15'h0005);
    check("busy_in_valid", out_valid, 1);
    tick();
    check("busy_in_idle", {in_ready, out_valid}, 2'b10);
    tick();
    in_valid = 1'b0;
    check("busy_in_acc2", busy, 1);
    tick();
    tick();
    tick();
    check("busy_in_C2", C, 15'h5555);
    tick();

    // Reset in MUL_HI abandons the operation
    in_valid = 1'b1;
    A = 8'h12;
    B = 8'h34;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_state", {out_valid, busy, in_ready}, 3'b001);
    check("mid_rst_C", C, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_rst_quiet", out_valid, 0);
    end

    // Random stream with random backpressure
    sent = 0;
    got  = 0;
    cyc  = 0;
    pa = 8'($urandom);
    pb = 8'($urandom);
    A = pa;
    B = pb;
    in_valid  = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    while (got < 1000 && cyc < 30000) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_spurious", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("rnd_C", C, exp_v);
        end
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(ref_clmul(pa, pb));
        sent++;
      end
      tick();
      cyc++;
      if (acc) begin
        pa = 8'($urandom);
        pb = 8'($urandom);
        A = pa;
        B = pb;
      end
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
    end
    check("rnd_count", got, 1000);
    check("rnd_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
